// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parameterised IEEE 1149.1 TAP controller with an
// instruction register, a 1-bit BYPASS register, an optional 32-bit IDCODE
// register and one user data register with parallel capture and update.
// Optional feature: define JTAG_IDCODE_EN to include the IDCODE register
// and opcode 1. Without it, opcode 1 decodes as BYPASS, and BYPASS becomes
// the reset instruction.
module jtag_tap_param #(
  parameter int          IR_WIDTH   = 4,
  parameter int          DR_WIDTH   = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h0A5A_5001,
  parameter int          USER_OP    = 2
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          state,
  input  logic [DR_WIDTH-1:0] user_dr_in,
  output logic [DR_WIDTH-1:0] user_dr_out
);

  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SEL_DR  = 4'h7,
    CAP_DR  = 4'h6,
    SH_DR   = 4'h2,
    EX1_DR  = 4'h1,
    PAU_DR  = 4'h3,
    EX2_DR  = 4'h0,
    UPD_DR  = 4'h5,
    SEL_IR  = 4'h4,
    CAP_IR  = 4'hE,
    SH_IR   = 4'hA,
    EX1_IR  = 4'h9,
    PAU_IR  = 4'hB,
    EX2_IR  = 4'h8,
    UPD_IR  = 4'hD
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] USER_CODE = IR_WIDTH'(USER_OP);
  localparam logic [IR_WIDTH-1:0] CAP_CODE  = IR_WIDTH'(2'b01);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] RESET_OP  = IDCODE_OP;
`else
  localparam logic [IR_WIDTH-1:0] RESET_OP  = {IR_WIDTH{1'b1}};
`endif

  tap_state_t          cur;
  tap_state_t          nxt;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir;
  logic                bypass_sr;
  logic [DR_WIDTH-1:0] user_sr;
  logic                sel_user;
  logic                sel_idcode;
  logic                tdo_next;
`ifdef JTAG_IDCODE_EN
  logic [31:0]         idcode_sr;
`endif

  // TAP state register; TRST forces Test-Logic-Reset immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) cur <= TLR;
    else      cur <= nxt;
  end

  // Standard 1149.1 TMS transition table.
  always_comb begin
    nxt = cur;
    unique case (cur)
      TLR:    nxt = tms ? TLR    : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR    : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

  // Instruction decode; anything that is not USER or IDCODE acts as BYPASS.
  always_comb begin
    sel_user   = (ir == USER_CODE);
    sel_idcode = 1'b0;
`ifdef JTAG_IDCODE_EN
    sel_idcode = !sel_user && (ir == IDCODE_OP);
`endif
  end

  // IR shift register: capture the fixed 01 pattern, then shift right.
  // NOTE: shift registers are flops on the TRST reset net, so they clear asynchronously too.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr <= '0;
    end else if (cur == CAP_IR) begin
      ir_sr <= CAP_CODE;
    end else if (cur == SH_IR) begin
      ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
    end
  end

  // Active instruction: loaded only in Update-IR, forced on entry to TLR.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir <= RESET_OP;
    end else if (nxt == TLR) begin
      ir <= RESET_OP;
    end else if (cur == UPD_IR) begin
      ir <= ir_sr;
    end
  end

  // BYPASS register: captures 0, then passes TDI through one stage.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      bypass_sr <= 1'b0;
    end else if (!sel_user && !sel_idcode) begin
      if (cur == CAP_DR)     bypass_sr <= 1'b0;
      else if (cur == SH_DR) bypass_sr <= tdi;
    end
  end

`ifdef JTAG_IDCODE_EN
  // IDCODE register: captures the device ID, shifted out LSB first.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      idcode_sr <= '0;
    end else if (sel_idcode) begin
      if (cur == CAP_DR)     idcode_sr <= IDCODE_VAL;
      else if (cur == SH_DR) idcode_sr <= {tdi, idcode_sr[31:1]};
    end
  end
`endif

  // User shift register; the shift expression also covers DR_WIDTH == 1.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      user_sr <= '0;
    end else if (sel_user) begin
      if (cur == CAP_DR)     user_sr <= user_dr_in;
      else if (cur == SH_DR) user_sr <= (user_sr >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));
    end
  end

  // Parallel user output: changes only in Update-DR with USER active.
  always_ff @(posedge tck or posedge trst) begin
    if (trst)                         user_dr_out <= '0;
    else if (cur == UPD_DR && sel_user) user_dr_out <= user_sr;
  end

  // Select the LSB of whichever register is shifting; 0 elsewhere.
  always_comb begin
    tdo_next = 1'b0;
    if (cur == SH_IR) begin
      tdo_next = ir_sr[0];
    end else if (cur == SH_DR) begin
      if (sel_user)        tdo_next = user_sr[0];
`ifdef JTAG_IDCODE_EN
      else if (sel_idcode) tdo_next = idcode_sr[0];
`endif
      else                 tdo_next = bypass_sr;
    end
  end

  // TDO is launched on the falling edge so the far end samples it cleanly on rising TCK.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) tdo <= 1'b0;
    else      tdo <= tdo_next;
  end

  assign tdo_en = (cur == SH_DR) || (cur == SH_IR);
  assign state  = cur;

endmodule
